key_event_decoder: RTL and testbench

Downstream consumer of the PS/2 keyboard driver. It takes each completed scan code (`code`, `ext`, `back`) with a one-cycle strobe and turns it into a press/release event. Events are queued in a small FIFO with a valid/ready handshake toward game logic. It also keeps a live held-key bitmap for the eight movement keys: the arrows plus W/A/S/D.

---
 rtl/key_event_decoder.sv | 100 ++++++++++
 tb/tb_key_event_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Turns PS/2 scan-code strobes into press/release events queued in a small FIFO,
// and tracks the held state of the arrow and WASD keys. Define KBD_AUTOREPEAT_FILTER_EN to drop typematic repeats.
module key_event_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       back,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_release,
    output logic [7:0] held,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic [7:0] hit;
    logic [7:0] held_next;
    logic       qualified;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic [9:0] head;

    always_comb begin
        hit    = '0;
        hit[0] = ext  && (code == 8'h75);
        hit[1] = ext  && (code == 8'h72);
        hit[2] = ext  && (code == 8'h6B);
        hit[3] = ext  && (code == 8'h74);
        hit[4] = !ext && (code == 8'h1D);
        hit[5] = !ext && (code == 8'h1C);
        hit[6] = !ext && (code == 8'h1B);
        hit[7] = !ext && (code == 8'h23);

        qualified = code_valid && (code != 8'h00) && (code != 8'hFF);

        held_next = held;
        if (qualified)
            held_next = back ? (held & ~hit) : (held | hit);

`ifdef KBD_AUTOREPEAT_FILTER_EN
        // A make of a tracked key that is already held is a typematic repeat
        push_req = qualified && !(!back && ((hit & held) != '0));
`else
        push_req = qualified;
`endif

        pop     = event_valid && event_ready;
        push_ok = push_req && ((count != DEPTH_CNT) || pop);
    end

    assign head          = mem[rd_ptr];
    assign event_valid   = (count != '0);
    assign event_code    = head[7:0];
    assign event_release = head[8];
    assign event_ext     = head[9];
    assign fifo_full     = (count == DEPTH_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            held     <= '0;
            overflow <= 1'b0;
        end else begin
            held <= held_next;
            if (push_ok) begin
                mem[wr_ptr] <= {ext, back, code};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed, table-driven check of key_event_decoder plus hand sequences for FIFO corner cases.
module tb_key_event_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       code_valid;
    logic [7:0] code;
    logic       ext;
    logic       back;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_release;
    logic [7:0] held;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    key_event_decoder #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .code_valid(code_valid), .code(code),
        .ext(ext), .back(back), .event_valid(event_valid), .event_ready(event_ready),
        .event_code(event_code), .event_ext(event_ext), .event_release(event_release),
        .held(held), .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] code;
        logic       ext;
        logic       back;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_code;
        logic       e_ext;
        logic       e_rel;
        logic [7:0] e_held;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        code_valid = 1'b0; code = '0; ext = 1'b0; back = 1'b0; event_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive one strobe at the falling edge, then sample 1 time unit after the rising edge
    task automatic step(input logic cv, input logic [7:0] c, input logic e, input logic b, input logic r);
        @(negedge clk);
        code_valid = cv; code = c; ext = e; back = b; event_ready = r;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    initial begin
        int evcnt;
        logic [7:0] exp_codes[4];

        // cv code ext back rdy | valid code ext rel held full ovf
        vecs[0]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0,  1'b1, 8'h1C, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h75, 1'b1, 1'b0, 1'b1,  1'b1, 8'h75, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h75, 1'b1, 1'b1, 1'b1,  1'b1, 8'h75, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 1'b0,  1'b1, 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h23, 1'b0, 1'b1, 1'b0,  1'b1, 8'h1C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 8'h23, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0,  1'b1, 8'h16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        #1;
        chk("reset_valid", event_valid, 1'b0);
        chk("reset_code", event_code, 8'h00);
        chk("reset_held", held, 8'h00);
        chk("reset_full", fifo_full, 1'b0);
        chk("reset_ovf", overflow, 1'b0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].cv, vecs[i].code, vecs[i].ext, vecs[i].back, vecs[i].rdy);
            chk($sformatf("v%0d_valid", i), event_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_code", i), event_code, vecs[i].e_code);
                chk($sformatf("v%0d_ext", i), event_ext, vecs[i].e_ext);
                chk($sformatf("v%0d_rel", i), event_release, vecs[i].e_rel);
            end
            chk($sformatf("v%0d_held", i), held, vecs[i].e_held);
            chk($sformatf("v%0d_full", i), fifo_full, vecs[i].e_full);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
        end

        // Overflow: five pushes into a depth-4 FIFO with no consumer
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                chk("ovf_full4", fifo_full, 1'b1);
                chk("ovf_ovf4", overflow, 1'b0);
            end
        end
        chk("ovf_full5", fifo_full, 1'b1);
        chk("ovf_ovf5", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            event_ready = 1'b1;
            chk($sformatf("ovf_drain%0d_valid", i), event_valid, 1'b1);
            chk($sformatf("ovf_drain%0d_code", i), event_code, 8'h10 + 8'(i));
        end
        @(negedge clk);
        chk("ovf_empty", event_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fpp_full_before", fifo_full, 1'b1);
        step(1'b1, 8'h23, 1'b0, 1'b0, 1'b1);
        event_ready = 1'b0;
        chk("fpp_full_after", fifo_full, 1'b1);
        chk("fpp_ovf", overflow, 1'b0);
        chk("fpp_held", held, 8'h80);
        exp_codes[0] = 8'h32; exp_codes[1] = 8'h33; exp_codes[2] = 8'h34; exp_codes[3] = 8'h23;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            event_ready = 1'b1;
            chk($sformatf("fpp_drain%0d", i), event_code, exp_codes[i]);
        end
        @(negedge clk);
        chk("fpp_empty", event_valid, 1'b0);

        // Typematic repeat of W with the consumer always ready
        do_reset();
        evcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(i < 3, 8'h1D, 1'b0, 1'b0, 1'b1);
            if (event_valid) evcnt++;
        end
`ifdef KBD_AUTOREPEAT_FILTER_EN
        chk("rep_events", evcnt, 1);
`else
        chk("rep_events", evcnt, 3);
`endif
        chk("rep_held", held, 8'h10);

        // Error codes and asynchronous reset with events queued
        do_reset();
        step(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("err_ovf_pre", overflow, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("err_held", held, 8'h40);
        chk("err_head", event_code, 8'h1B);
        chk("err_full", fifo_full, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", event_valid, 1'b0);
        chk("arst_held", held, 8'h00);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_full", fifo_full, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
